// File: rtl/multi_port_banked_ram.sv
// N-port, M-bank shared 32-bit word memory with one Wishbone classic slave per port.
// Each bank serves one access per cycle; per-bank round-robin arbiters stall losing ports.
module multi_port_banked_ram #(
    parameter int NUM_PORTS      = 2,
    parameter int NUM_BANKS      = 2,
    parameter int WORDS_PER_BANK = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS*32-1:0] p_wb_addr_i,
    input  logic [NUM_PORTS*32-1:0] p_wb_data_i,
    input  logic [NUM_PORTS*4-1:0]  p_wb_sel_i,
    input  logic [NUM_PORTS-1:0]    p_wb_we_i,
    input  logic [NUM_PORTS-1:0]    p_wb_stb_i,
    input  logic [NUM_PORTS-1:0]    p_wb_cyc_i,
    output logic [NUM_PORTS*32-1:0] p_wb_data_o,
    output logic [NUM_PORTS-1:0]    p_wb_ack_o,
    output logic [NUM_PORTS-1:0]    p_wb_stall_o
);

    localparam int WB = (WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1;
    localparam int BB = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PB = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [31:0]          mem_q   [NUM_BANKS][WORDS_PER_BANK];
    logic [31:0]          data_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0] ack_q;
    logic [NUM_PORTS-1:0] ack_d;
    logic [PB-1:0]        last_q  [NUM_BANKS];

    logic [WB-1:0]        word_of [NUM_PORTS];
    logic [BB-1:0]        bank_of [NUM_PORTS];
    logic [31:0]          wdat    [NUM_PORTS];
    logic [3:0]           sel     [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_BANKS-1:0] gnt_valid;
    logic [PB-1:0]        gnt_port [NUM_BANKS];
    logic                 unused_addr_bits;
    int unsigned          idx;

    always_comb begin
        unused_addr_bits = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            word_of[p] = WB'(p_wb_addr_i[p*32 +: 32] >> 2);
            bank_of[p] = (NUM_BANKS > 1) ? BB'(p_wb_addr_i[p*32 +: 32] >> (2 + WB)) : '0;
            wdat[p]    = p_wb_data_i[p*32 +: 32];
            sel[p]     = p_wb_sel_i[p*4 +: 4];
            unused_addr_bits = unused_addr_bits ^ (^p_wb_addr_i[p*32 +: 32]);
        end
        // A port in its ack cycle is ineligible, so a held strobe is not a second access.
        req = p_wb_cyc_i & p_wb_stb_i & ~ack_q;
    end

    // Scan ports starting just after the last winner of each bank.
    always_comb begin
        grant     = '0;
        gnt_valid = '0;
        idx       = 0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            gnt_port[b] = '0;
            for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
                idx = (int'(last_q[b]) + i) % NUM_PORTS;
                if (!gnt_valid[b] && req[idx] && bank_of[idx] == BB'(b)) begin
                    gnt_valid[b] = 1'b1;
                    grant[idx]   = 1'b1;
                    gnt_port[b]  = PB'(idx);
                end
            end
        end
        ack_d = grant;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (gnt_valid[b] && p_wb_we_i[gnt_port[b]]) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (sel[gnt_port[b]][k])
                            mem_q[b][word_of[gnt_port[b]]][8*k +: 8] <= wdat[gnt_port[b]][8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) data_q[p] <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) last_q[b] <= PB'(NUM_PORTS - 1);
        end else begin
            ack_q <= ack_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (grant[p] && !p_wb_we_i[p])
                    data_q[p] <= mem_q[bank_of[p]][word_of[p]];
            end
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (gnt_valid[b]) last_q[b] <= gnt_port[b];
            end
        end
    end

    always_comb begin
        p_wb_data_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) p_wb_data_o[p*32 +: 32] = data_q[p];
    end

    assign p_wb_ack_o   = ack_q;
    assign p_wb_stall_o = req & ~grant;

endmodule

// File: tb/tb_multi_port_banked_ram.sv
// Directed bench for multi_port_banked_ram: a default 2-port/2-bank instance and a
// 4-port/1-bank instance for round-robin fairness.
module tb_multi_port_banked_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] a_addr, a_wdat, a_rdat;
    logic [7:0]  a_sel;
    logic [1:0]  a_we, a_stb, a_cyc, a_ack, a_stall;

    logic [127:0] b_addr, b_wdat, b_rdat;
    logic [15:0]  b_sel;
    logic [3:0]   b_we, b_stb, b_cyc, b_ack, b_stall;

    int unsigned total = 0;
    int unsigned bad   = 0;

    multi_port_banked_ram #(.NUM_PORTS(2), .NUM_BANKS(2), .WORDS_PER_BANK(256)) dut (
        .clk(clk), .rst(rst),
        .p_wb_addr_i(a_addr), .p_wb_data_i(a_wdat), .p_wb_sel_i(a_sel),
        .p_wb_we_i(a_we), .p_wb_stb_i(a_stb), .p_wb_cyc_i(a_cyc),
        .p_wb_data_o(a_rdat), .p_wb_ack_o(a_ack), .p_wb_stall_o(a_stall)
    );

    multi_port_banked_ram #(.NUM_PORTS(4), .NUM_BANKS(1), .WORDS_PER_BANK(256)) dut4 (
        .clk(clk), .rst(rst),
        .p_wb_addr_i(b_addr), .p_wb_data_i(b_wdat), .p_wb_sel_i(b_sel),
        .p_wb_we_i(b_we), .p_wb_stb_i(b_stb), .p_wb_cyc_i(b_cyc),
        .p_wb_data_o(b_rdat), .p_wb_ack_o(b_ack), .p_wb_stall_o(b_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel);
        a_addr[p*32 +: 32] = addr;
        a_wdat[p*32 +: 32] = data;
        a_sel[p*4 +: 4]    = sel;
        a_we[p]  = we;
        a_stb[p] = 1'b1;
        a_cyc[p] = 1'b1;
    endtask

    task automatic release_port(input int p);
        a_we[p]  = 1'b0;
        a_stb[p] = 1'b0;
        a_cyc[p] = 1'b0;
    endtask

    // Single uncontended access on one port; checks the 1-cycle ack and returns read data.
    task automatic single(input string tag, input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel, output logic [31:0] rd);
        drive(p, we, addr, data, sel);
        @(negedge clk);
        check({tag, "_ack"}, 32'(a_ack[p]), 32'd1);
        rd = a_rdat[p*32 +: 32];
        release_port(p);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        a_addr = '0; a_wdat = '0; a_sel = '0; a_we = '0; a_stb = '0; a_cyc = '0;
        b_addr = '0; b_wdat = '0; b_sel = '0; b_we = '0; b_stb = '0; b_cyc = '0;
        @(negedge clk);
        do_reset();
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_data", a_rdat[31:0], 32'd0);
        check("rst_stall", 32'(a_stall), 32'd0);

        // Single port write then read
        drive(0, 1'b1, 32'h000, 32'hDEADBEEF, 4'hF);
        #1 check("wr_stall", 32'(a_stall), 32'd0);
        @(negedge clk);
        check("wr_ack", 32'(a_ack), 32'd1);
        release_port(0);
        @(negedge clk);
        check("wr_ack_drop", 32'(a_ack), 32'd0);
        drive(0, 1'b0, 32'h000, 32'h0, 4'h0);
        #1 check("rd_stall", 32'(a_stall), 32'd0);
        @(negedge clk);
        check("rd_ack", 32'(a_ack), 32'd1);
        check("rd_data", a_rdat[31:0], 32'hDEADBEEF);
        check("rd_ack_stall", 32'(a_stall), 32'd0);
        release_port(0);
        @(negedge clk);

        // Byte lanes
        single("bl_w1", 0, 1'b1, 32'h010, 32'hFFFFFFFF, 4'hF, rd);
        single("bl_w2", 0, 1'b1, 32'h010, 32'h11223344, 4'h5, rd);
        single("bl_rd", 0, 1'b0, 32'h010, 32'h0, 4'h0, rd);
        check("bl_data", rd, 32'hFF22FF44);

        // Parallel banks
        drive(0, 1'b1, 32'h004, 32'h12345678, 4'hF);
        drive(1, 1'b1, 32'h404, 32'h87654321, 4'hF);
        #1 check("par_stall", 32'(a_stall), 32'd0);
        @(negedge clk);
        check("par_ack", 32'(a_ack), 32'd3);
        release_port(0);
        release_port(1);
        @(negedge clk);
        single("par_rd0", 0, 1'b0, 32'h004, 32'h0, 4'h0, rd);
        check("par_data0", rd, 32'h12345678);
        single("par_rd1", 1, 1'b0, 32'h404, 32'h0, 4'h0, rd);
        check("par_data1", rd, 32'h87654321);

        // Same-bank conflict after reset: port 0 wins first
        do_reset();
        drive(0, 1'b1, 32'h008, 32'hAAAABBBB, 4'hF);
        drive(1, 1'b1, 32'h00C, 32'hCCCCDDDD, 4'hF);
        #1 check("cf_stall_n", 32'(a_stall), 32'd2);
        @(negedge clk);
        check("cf_ack_n1", 32'(a_ack), 32'd1);
        release_port(0);
        #1 check("cf_stall_n1", 32'(a_stall), 32'd0);
        @(negedge clk);
        check("cf_ack_n2", 32'(a_ack), 32'd2);
        release_port(1);
        @(negedge clk);
        check("cf_ack_idle", 32'(a_ack), 32'd0);
        single("cf_rd0", 0, 1'b0, 32'h008, 32'h0, 4'h0, rd);
        check("cf_data0", rd, 32'hAAAABBBB);
        single("cf_rd1", 0, 1'b0, 32'h00C, 32'h0, 4'h0, rd);
        check("cf_data1", rd, 32'hCCCCDDDD);

        // Bank 0 last winner is now port 0, so port 1 goes first
        drive(0, 1'b0, 32'h008, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h00C, 32'h0, 4'h0);
        #1 check("rr_stall_n", 32'(a_stall), 32'd1);
        @(negedge clk);
        check("rr_ack_n1", 32'(a_ack), 32'd2);
        check("rr_data1", a_rdat[63:32], 32'hCCCCDDDD);
        release_port(1);
        @(negedge clk);
        check("rr_ack_n2", 32'(a_ack), 32'd1);
        check("rr_data0", a_rdat[31:0], 32'hAAAABBBB);
        release_port(0);
        @(negedge clk);

        // Reset in the grant cycle of a write
        single("mr_pre", 0, 1'b1, 32'h020, 32'h5A5A5A5A, 4'hF, rd);
        rst = 1'b1;
        drive(0, 1'b1, 32'h020, 32'hBADBAD00, 4'hF);
        @(negedge clk);
        check("mr_ack", 32'(a_ack), 32'd0);
        check("mr_data0", a_rdat[31:0], 32'd0);
        rst = 1'b0;
        release_port(0);
        single("mr_old", 1, 1'b0, 32'h020, 32'h0, 4'h0, rd);
        check("mr_old_data", rd, 32'h5A5A5A5A);
        drive(0, 1'b1, 32'h020, 32'hBADBAD00, 4'hF);
        @(negedge clk);
        check("mr_reissue_ack", 32'(a_ack), 32'd1);
        check("mr_reissue_data", a_rdat[31:0], 32'd0);
        release_port(0);
        @(negedge clk);
        single("mr_rd", 0, 1'b0, 32'h020, 32'h0, 4'h0, rd);
        check("mr_new_data", rd, 32'hBADBAD00);

        // Fairness: 4 ports hammering a single bank
        do_reset();
        for (int p = 0; p < 4; p++) b_addr[p*32 +: 32] = 32'(p * 4);
        b_we  = 4'h0;
        b_stb = 4'hF;
        b_cyc = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr4_ack%0d", i), 32'(b_ack), 32'(4'b0001 << (i % 4)));
        end
        b_stb = 4'h0;
        b_cyc = 4'h0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
